alu_exec_unit: RTL and testbench

//   Multi-cycle 8-bit ALU; the consumer of the 3-bit ALU control code produced by the opcode->aluCtrl decoder.

---
 rtl/alu_exec_unit.sv | 139 +++++++++++++
 tb/tb_alu_exec_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage 8-bit ALU with valid/ready handshake.
// SLL/SRL iterate one bit per cycle; all other ops finish in one cycle.
module alu_exec_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam logic [2:0] AND_ALU = 3'b000;
  localparam logic [2:0] OR_ALU  = 3'b001;
  localparam logic [2:0] ADD_ALU = 3'b010;
  localparam logic [2:0] SLL_ALU = 3'b011;
  localparam logic [2:0] SRL_ALU = 3'b100;
  localparam logic [2:0] NOR_ALU = 3'b101;
  localparam logic [2:0] SUB_ALU = 3'b110;
  localparam logic [2:0] SLT_ALU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sh_val;
  logic [SHAMT_W-1:0] cnt;
  logic               sh_left;

  logic               accept;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   res_c;
  logic               ovf_c;
  logic [WIDTH-1:0]   sh_nxt;

  assign in_ready = !rst &&
    ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_ctrl == SLL_ALU) ||
                    (alu_ctrl == SRL_ALU);
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign sh_nxt   = sh_left ? (sh_val << 1) : (sh_val >> 1);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (alu_ctrl)
      ADD_ALU: begin
        res_c = sum;
        ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      SUB_ALU: begin
        res_c = diff;
        ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      SLT_ALU: res_c = {{(WIDTH-1){1'b0}},
                        ($signed(op_a) < $signed(op_b))};
      AND_ALU: res_c = op_a & op_b;
      OR_ALU:  res_c = op_a | op_b;
      NOR_ALU: res_c = ~(op_a | op_b);
      // zero-distance shifts bypass the iterator
      SLL_ALU: res_c = op_a;
      SRL_ALU: res_c = op_a;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_val    <= '0;
      cnt       <= '0;
      sh_left   <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          sh_val <= sh_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state     <= DONE;
            result    <= sh_nxt;
            zero      <= (sh_nxt == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        IDLE, DONE: begin
          if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state     <= SHIFT;
              sh_val    <= op_a;
              cnt       <= shamt;
              sh_left   <= (alu_ctrl == SLL_ALU);
              out_valid <= 1'b0;
              busy      <= 1'b1;
            end else begin
              state     <= DONE;
              result    <= res_c;
              zero      <= (res_c == '0);
              ovf       <= ovf_c;
              out_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal cases plus
// randomized traffic against a transaction-level model.
module tb_alu_exec_unit;

  localparam logic [2:0] AND_ALU = 3'b000;
  localparam logic [2:0] OR_ALU  = 3'b001;
  localparam logic [2:0] ADD_ALU = 3'b010;
  localparam logic [2:0] SLL_ALU = 3'b011;
  localparam logic [2:0] SRL_ALU = 3'b100;
  localparam logic [2:0] NOR_ALU = 3'b101;
  localparam logic [2:0] SUB_ALU = 3'b110;
  localparam logic [2:0] SLT_ALU = 3'b111;

  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [2:0] alu_ctrl = 0;
  logic [7:0] op_a = 0;
  logic [7:0] op_b = 0;
  logic       out_valid;
  logic       out_ready = 0;
  logic [7:0] result;
  logic       zero;
  logic       ovf;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model_op(input int c, input int a, input int b,
                          output int r, output int o, output int lat);
    int s;
    r = 0; o = 0; lat = 0;
    case (c)
      ADD_ALU: begin
        s = sgn(a) + sgn(b);
        r = (a + b) % 256;
        o = (s > 127 || s < -128) ? 1 : 0;
      end
      SUB_ALU: begin
        s = sgn(a) - sgn(b);
        r = (a - b + 256) % 256;
        o = (s > 127 || s < -128) ? 1 : 0;
      end
      SLT_ALU: r = (sgn(a) < sgn(b)) ? 1 : 0;
      AND_ALU: r = a & b;
      OR_ALU:  r = a | b;
      NOR_ALU: r = 255 - (a | b);
      SLL_ALU: begin r = (a << (b % 8)) % 256; lat = b % 8; end
      SRL_ALU: begin r = a >> (b % 8); lat = b % 8; end
      default: r = 0;
    endcase
  endtask

  bit m_pend = 0;
  int m_rem = 0;
  int m_res = 0;
  int m_ovf = 0;
  bit m_rst = 0;
  bit started = 0;

  always @(posedge clk) begin
    bit rdy;
    int r, o, l;
    started = 1;
    if (rst) begin
      m_pend = 0; m_rem = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      rdy = !m_pend || (m_rem == 0 && out_ready);
      if (m_pend && m_rem == 0 && out_ready) m_pend = 0;
      else if (m_pend && m_rem > 0) m_rem--;
      if (rdy && in_valid) begin
        model_op(alu_ctrl, op_a, op_b, r, o, l);
        m_pend = 1; m_res = r; m_ovf = o; m_rem = l;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready,
          (!rst && (!m_pend || (m_rem == 0 && out_ready))) ? 1 : 0);
      chk("out_valid", out_valid, (m_pend && m_rem == 0) ? 1 : 0);
      chk("busy", busy, (m_pend && m_rem > 0) ? 1 : 0);
      if (m_pend && m_rem == 0) begin
        chk("result", result, m_res);
        chk("zero", zero, (m_res == 0) ? 1 : 0);
        chk("ovf", ovf, m_ovf);
      end
      if (m_rst) begin
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [7:0] a,
                       input logic [7:0] b);
    bit ok;
    in_valid = 1; alu_ctrl = c; op_a = a; op_b = b;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_valid(output int lat, output int nbusy);
    bit ok;
    lat = 0; nbusy = 0; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      ok = out_valid;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic directed(input string nm, input logic [2:0] c,
                          input logic [7:0] a, input logic [7:0] b,
                          input int er, input int ez, input int eo,
                          input int elat);
    int lat, nb;
    issue(c, a, b);
    wait_valid(lat, nb);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_res"}, result, er);
    chk({nm, "_zero"}, zero, ez);
    chk({nm, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, nb;
    repeat (3) @(posedge clk);
    #1 rst = 0; out_ready = 1;
    @(posedge clk); #1;

    directed("add", ADD_ALU, 8'h7F, 8'h01, 8'h80, 0, 1, 1);
    directed("sub", SUB_ALU, 8'h05, 8'h05, 8'h00, 1, 0, 1);
    directed("slt", SLT_ALU, 8'hFF, 8'h01, 8'h01, 0, 0, 1);
    directed("srl0", SRL_ALU, 8'h80, 8'h00, 8'h80, 0, 0, 1);

    issue(SLL_ALU, 8'h01, 8'h05);
    wait_valid(lat, nb);
    chk("sll_lat", lat, 6);
    chk("sll_busy_cycles", nb, 5);
    chk("sll_res", result, 8'h20);
    @(posedge clk); #1;

    // backpressure then back-to-back accept while draining
    out_ready = 0;
    issue(NOR_ALU, 8'h0F, 8'hF0);
    wait_valid(lat, nb);
    chk("nor_lat", lat, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_res", result, 8'h00);
      chk("bp_zero", zero, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1; in_valid = 1;
    alu_ctrl = AND_ALU; op_a = 8'hCC; op_b = 8'hAA;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_res", result, 8'h88);
    @(posedge clk); #1;

    // reset in the middle of a long shift
    issue(SLL_ALU, 8'h01, 8'h07);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_valid", out_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_res", result, 0);
    chk("rs_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rs_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_ctrl  = 3'($urandom_range(0, 7));
      op_a      = 8'($urandom);
      op_b      = 8'($urandom);
      if ($urandom_range(0, 7) == 0) op_b = op_a;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (12) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
